// File: rtl/snes_pad_mmio.sv
// SNES game-pad initiator on the dmem bus: polls 16 buttons over latch/clock/data and exposes them as registers.
// Optional EDGES register (pressed-since-clear) is built only when SNES_PAD_EDGES_EN is defined.
module snes_pad_mmio #(
    parameter logic [12:0] BASE_ADDR    = 13'h1F00,
    parameter int          CLK_DIV      = 150,
    parameter int          LATCH_CYCLES = 600,
    parameter int          POLL_PERIOD  = 833333
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [12:0] address,
    input  logic [31:0] data_in,
    input  logic        wren,
    output logic [31:0] data_out,
    output logic        pad_latch,
    output logic        pad_clk,
    input  logic        pad_data
);
    localparam int CNT_MAX = (LATCH_CYCLES > CLK_DIV) ? LATCH_CYCLES : CLK_DIV;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TW      = $clog2(POLL_PERIOD + 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [TW-1:0] POLL_LAST  = TW'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_HI     = 3'd2,
        S_LO     = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    idx_q;
    logic [15:0]   shift_q;
    logic [TW-1:0] timer_q;
    logic          pad_latch_q;
    logic          pad_clk_q;
    logic [15:0]   buttons_q, buttons_d;
    logic          fresh_q, fresh_d;
    logic          poll_en_q, poll_en_d;

    logic [12:0]   off_s;
    logic          sel_s;
    logic          wr_status_s;
    logic          wr_ctrl_s;
    logic          busy_s;
    logic          commit_s;
    logic          timer_hit_s;
    logic          start_s;
    logic          unused_data_s;

    // Offsets below BASE_ADDR wrap to large values, so one compare covers the window.
    assign off_s       = address - BASE_ADDR;
    assign sel_s       = (off_s < 13'd3);
    assign wr_status_s = wren && sel_s && (off_s == 13'd0);
    assign wr_ctrl_s   = wren && sel_s && (off_s == 13'd2);
    assign busy_s      = (state_q != S_IDLE);
    assign commit_s    = (state_q == S_COMMIT);
    assign timer_hit_s = poll_en_q && (timer_q == POLL_LAST);
    assign start_s     = !busy_s && (timer_hit_s || (wr_ctrl_s && data_in[1]));
    assign pad_latch   = pad_latch_q;
    assign pad_clk     = pad_clk_q;

`ifdef SNES_PAD_EDGES_EN
    logic        wr_edges_s;
    logic [15:0] edges_q, edges_d;
    assign wr_edges_s    = wren && sel_s && (off_s == 13'd1);
    assign unused_data_s = ^data_in[31:16];
`else
    assign unused_data_s = ^data_in[31:2];
`endif

    // Poll timer and pad protocol sequencer with registered pad outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= 4'd0;
            shift_q     <= 16'd0;
            timer_q     <= '0;
            pad_latch_q <= 1'b0;
            pad_clk_q   <= 1'b1;
        end else begin
            if (!poll_en_q) begin
                timer_q <= '0;
            end else if (!busy_s) begin
                timer_q <= timer_hit_s ? '0 : timer_q + TW'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (start_s) begin
                        state_q     <= S_LATCH;
                        cnt_q       <= '0;
                        pad_latch_q <= 1'b1;
                    end
                end
                S_LATCH: begin
                    if (cnt_q == LATCH_LAST) begin
                        state_q     <= S_HI;
                        cnt_q       <= '0;
                        idx_q       <= 4'd0;
                        pad_latch_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_HI: begin
                    if (cnt_q == DIV_LAST) begin
                        shift_q[idx_q] <= ~pad_data;
                        state_q        <= S_LO;
                        cnt_q          <= '0;
                        pad_clk_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_LO: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q     <= '0;
                        pad_clk_q <= 1'b1;
                        if (idx_q == 4'd15) begin
                            state_q <= S_COMMIT;
                        end else begin
                            state_q <= S_HI;
                            idx_q   <= idx_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_COMMIT: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q     <= S_IDLE;
                    pad_latch_q <= 1'b0;
                    pad_clk_q   <= 1'b1;
                end
            endcase
        end
    end

    // Next-state for the bus-visible registers; a COMMIT set beats a same-cycle clear.
    always_comb begin
        buttons_d = buttons_q;
        fresh_d   = fresh_q;
        poll_en_d = poll_en_q;
        if (commit_s) begin
            buttons_d = shift_q;
            fresh_d   = 1'b1;
        end else if (wr_status_s) begin
            fresh_d   = 1'b0;
        end else begin
            fresh_d   = fresh_q;
        end
        if (wr_ctrl_s) begin
            poll_en_d = data_in[0];
        end else begin
            poll_en_d = poll_en_q;
        end
`ifdef SNES_PAD_EDGES_EN
        edges_d = edges_q;
        if (wr_edges_s) begin
            edges_d = edges_d & ~data_in[15:0];
        end else begin
            edges_d = edges_q;
        end
        if (commit_s) begin
            edges_d = edges_d | (shift_q & ~buttons_q);
        end else begin
            edges_d = edges_d;
        end
`endif
    end

    // Bus-visible register state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buttons_q <= 16'd0;
            fresh_q   <= 1'b0;
            poll_en_q <= 1'b0;
`ifdef SNES_PAD_EDGES_EN
            edges_q   <= 16'd0;
`endif
        end else begin
            buttons_q <= buttons_d;
            fresh_q   <= fresh_d;
            poll_en_q <= poll_en_d;
`ifdef SNES_PAD_EDGES_EN
            edges_q   <= edges_d;
`endif
        end
    end

    // Read mux; zero outside the window so the parent can OR it onto the bus.
    always_comb begin
        data_out = 32'd0;
        if (sel_s) begin
            case (off_s)
                13'd0:   data_out = {14'd0, busy_s, fresh_q, buttons_q};
`ifdef SNES_PAD_EDGES_EN
                13'd1:   data_out = {16'd0, edges_q};
`else
                13'd1:   data_out = 32'd0;
`endif
                13'd2:   data_out = {31'd0, poll_en_q};
                default: data_out = 32'd0;
            endcase
        end else begin
            data_out = 32'd0;
        end
    end
endmodule

// File: tb/tb_snes_pad_mmio.sv
// Self-checking bench for snes_pad_mmio: register vector table, pad shift-register model, protocol timing sequences.
module tb_snes_pad_mmio;
    localparam logic [12:0] A_STAT = 13'h1F00;
    localparam logic [12:0] A_EDGE = 13'h1F01;
    localparam logic [12:0] A_CTRL = 13'h1F02;
`ifdef SNES_PAD_EDGES_EN
    localparam bit EDGES_ON = 1'b1;
`else
    localparam bit EDGES_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [12:0] address = 13'd0;
    logic [31:0] data_in = 32'd0;
    logic        wren = 1'b0;
    logic [31:0] data_out;
    logic        pad_latch;
    logic        pad_clk;
    logic        pad_data;

    logic [15:0] btn = 16'd0;
    logic [15:0] pad_sr = 16'hFFFF;
    logic        pclk_prev = 1'b1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    string       nm_q[$];

    typedef struct {
        logic        we;
        logic [12:0] waddr;
        logic [31:0] wdata;
        logic [12:0] raddr;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[9];

    snes_pad_mmio #(
        .BASE_ADDR(13'h1F00), .CLK_DIV(2), .LATCH_CYCLES(4), .POLL_PERIOD(100)
    ) dut (
        .clock(clock), .reset_n(reset_n), .address(address), .data_in(data_in),
        .wren(wren), .data_out(data_out), .pad_latch(pad_latch), .pad_clk(pad_clk),
        .pad_data(pad_data)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // 4021-style pad: parallel load while latched, shift on each pad_clk rise, active-low output.
    assign pad_data = pad_sr[0];
    always @(posedge clock) begin
        if (pad_latch) pad_sr <= ~btn;
        else if (pad_clk && !pclk_prev) pad_sr <= {1'b1, pad_sr[15:1]};
        pclk_prev <= pad_clk;
    end

    function automatic logic [31:0] ex_edges(input logic [15:0] x);
        return EDGES_ON ? {16'd0, x} : 32'd0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [12:0] a, input logic [31:0] e, input string nm);
        address = a;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        #1;
        check(nm_q.pop_front(), data_out, exp_q.pop_front());
    endtask

    task automatic wr(input logic [12:0] a, input logic [31:0] d);
        @(negedge clock);
        address = a;
        data_in = d;
        wren    = 1'b1;
        @(negedge clock);
        wren    = 1'b0;
    endtask

    // Force a poll and watch it; returns pad_latch-high cycles and pad_clk falls.
    task automatic do_poll(input logic [31:0] exp_commit, output int lat, output int falls);
        logic prev;
        lat = 0;
        falls = 0;
        wr(A_CTRL, 32'd2);
        prev = pad_clk;
        for (int k = 0; k < 69; k++) begin
            if (pad_latch) lat++;
            if (prev && !pad_clk) falls++;
            prev = pad_clk;
            if (k == 68) rd(A_STAT, exp_commit, "status_in_commit");
            @(negedge clock);
        end
    endtask

    initial begin
        int lat, falls, n, t1, t2;
        vt[0] = '{1'b1, 13'h1F03, 32'hFFFF_FFFF, A_STAT, 32'h0001_8005};
        vt[1] = '{1'b1, 13'h1EFF, 32'hFFFF_FFFF, A_EDGE, ex_edges(16'h8005)};
        vt[2] = '{1'b0, 13'h0000, 32'h0000_0000, 13'h1F03, 32'd0};
        vt[3] = '{1'b0, 13'h0000, 32'h0000_0000, 13'h1EFF, 32'd0};
        vt[4] = '{1'b1, A_STAT,   32'h0000_0000, A_STAT, 32'h0000_8005};
        vt[5] = '{1'b1, A_EDGE,   32'h0000_0001, A_EDGE, ex_edges(16'h8004)};
        vt[6] = '{1'b1, A_CTRL,   32'hFFFF_FFFD, A_CTRL, 32'd1};
        vt[7] = '{1'b1, A_CTRL,   32'h0000_0000, A_CTRL, 32'd0};
        vt[8] = '{1'b0, 13'h0000, 32'h0000_0000, A_STAT, 32'h0000_8005};

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_latch", {31'd0, pad_latch}, 32'd0);
        check("rst_clk", {31'd0, pad_clk}, 32'd1);
        reset_n = 1'b1;
        @(negedge clock);
        rd(A_STAT, 32'd0, "rst_status");
        rd(A_EDGE, 32'd0, "rst_edges");
        rd(A_CTRL, 32'd0, "rst_ctrl");

        // First forced poll
        btn = 16'h8005;
        do_poll(32'h0002_0000, lat, falls);
        check("latch_cycles", lat, 32'd4);
        check("clk_pulses", falls, 32'd16);
        rd(A_STAT, 32'h0001_8005, "poll1_status");
        rd(A_EDGE, ex_edges(16'h8005), "poll1_edges");
        rd(A_CTRL, 32'd0, "poll1_ctrl");

        // Register vector table
        for (int i = 0; i < 9; i++) begin
            if (vt[i].we) wr(vt[i].waddr, vt[i].wdata);
            rd(vt[i].raddr, vt[i].exp, $sformatf("vec%0d", i));
        end

        // Second poll: edge accumulation
        btn = 16'h8006;
        do_poll(32'h0002_8005, lat, falls);
        rd(A_STAT, 32'h0001_8006, "poll2_status");
        rd(A_EDGE, ex_edges(16'h8006), "poll2_edges");

        // Automatic polling and force-while-busy
        wr(A_CTRL, 32'd1);
        n = 0;
        while (!pad_latch && n < 300) begin @(negedge clock); n++; end
        check("auto_first_delay", n, 32'd100);
        t1 = cyc;
        wr(A_CTRL, 32'd3);
        rd(A_STAT, 32'h0003_8006, "busy_status");
        n = 0;
        while (pad_latch && n < 50) begin @(negedge clock); n++; end
        n = 0;
        while (!pad_latch && n < 400) begin @(negedge clock); n++; end
        t2 = cyc;
        check("auto_period", t2 - t1, 32'd169);
        wr(A_CTRL, 32'd0);
        repeat (80) @(negedge clock);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            if (pad_latch) n++;
            @(negedge clock);
        end
        check("poll_disabled", n, 32'd0);

        // EDGES clear coinciding with COMMIT
        btn = 16'h0009;
        wr(A_EDGE, 32'h0000_FFFF);
        wr(A_CTRL, 32'd2);
        repeat (67) @(negedge clock);
        wr(A_EDGE, 32'h0000_FFFF);
        rd(A_EDGE, ex_edges(16'h0009), "edge_set_wins");
        rd(A_STAT, 32'h0001_0009, "poll3_status");

        // fresh clear coinciding with COMMIT
        wr(A_STAT, 32'd0);
        wr(A_CTRL, 32'd2);
        repeat (67) @(negedge clock);
        wr(A_STAT, 32'd0);
        rd(A_STAT, 32'h0001_0009, "fresh_set_wins");
        rd(A_EDGE, ex_edges(16'h0009), "poll4_edges");

        // Reset mid-shift
        btn = 16'hFFFF;
        wr(A_CTRL, 32'd3);
        check("en_force_latch", {31'd0, pad_latch}, 32'd1);
        n = 0;
        while (pad_clk && n < 200) begin @(negedge clock); n++; end
        check("reach_clk_low", {31'd0, pad_clk}, 32'd0);
        reset_n = 1'b0;
        #1;
        check("midrst_latch", {31'd0, pad_latch}, 32'd0);
        check("midrst_clk", {31'd0, pad_clk}, 32'd1);
        rd(A_STAT, 32'd0, "midrst_status");
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (100) @(negedge clock);
        rd(A_STAT, 32'd0, "postrst_status");
        rd(A_EDGE, 32'd0, "postrst_edges");
        rd(A_CTRL, 32'd0, "postrst_ctrl");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/snes_pad_mmio.md
# snes_pad_mmio

Memory-mapped game-controller port on the processor's dmem bus, alongside the existing mmio responder. It acts as the initiator of the SNES serial pad protocol (latch/clock/data): it periodically shifts in 16 button bits and presents them as read-only registers that the processor polls with ordinary lw/sw accesses. Decode is by word address. data_out is zero when the address is outside this block's window, so the parent can OR it into q_dmem.

## Interface
- BASE_ADDR, 13'h1F00 — word address of register 0; window is BASE_ADDR..BASE_ADDR+2
- CLK_DIV, 150 — clock cycles per pad_clk half-period
- LATCH_CYCLES, 600 — clock cycles pad_latch is held high
- POLL_PERIOD, 833333 — clock cycles between automatic polls (60 Hz at 50 MHz)
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  13  dmem word address
- data_in  in  32  dmem write data
- wren  in  1  dmem write enable
- data_out  out  32  register read data; 0 when not selected
- pad_latch  out  1  pad latch, active high
- pad_clk  out  1  pad clock, idles high
- pad_data  in  1  pad serial data, active-low per button

## Operation
- Registers, by offset from BASE_ADDR:
  - Offset 0, STATUS (read-only data):
    - [15:0] buttons, 1 = pressed
    - [16] fresh
    - [17] busy
    - writing any value clears fresh
  - Offset 1, EDGES: [15:0] pressed-since-clear; write-1-to-clear.
  - Offset 2, CTRL: [0] poll_en (read/write); [1] force, write-only, reads 0.
- FSM states:
  - IDLE: start a poll when poll_en and the timer expires, or when force is written as 1. Go to LATCH.
  - LATCH: pad_latch=1 for LATCH_CYCLES, then go to HI with bit index 0.
  - HI: pad_clk=1 for CLK_DIV cycles. On the last cycle, shift in ~pad_data as bit[index].
  - LO: pad_clk=0 for CLK_DIV cycles. Then go to HI with index+1, or to COMMIT after index 15.
  - COMMIT: one cycle. Load buttons from the shift register, set fresh, update EDGES, go to IDLE.
- The shift register is private. Buttons change only in COMMIT, all 16 bits at once.
- EDGES update: EDGES |= new & ~old_buttons. If an EDGES clear and a set hit the same bit in the same cycle, set wins.
- fresh: if a clear and COMMIT's set coincide, set wins.
- busy = 1 in every state except IDLE.
- Poll timer:
  - counts only while poll_en=1 and the FSM is IDLE;
  - resets to 0 when poll_en=0;
  - expires at POLL_PERIOD-1, which starts a poll and resets the count to 0.
- force written while busy is ignored; it is not queued.
- A write to CTRL that sets poll_en=1 and force=1 together starts a poll immediately.
- Writes to unmapped window offsets and to addresses outside the window are ignored.

## Timing
- Reset values while reset_n=0, taking effect immediately:
  - pad_latch=0, pad_clk=1
  - buttons, EDGES, fresh, poll_en, timer all 0
  - FSM in IDLE
- Reset mid-poll abandons the shift and leaves buttons at 0.
- data_out is combinational from address and current register state: valid the same cycle, no read side effects.
- A write takes effect on the rising edge where wren=1 and the address hits.
- A force write sets pad_latch=1 on the next edge.
- Poll length: LATCH_CYCLES + 32·CLK_DIV + 1 cycles from the first latch cycle to fresh=1.
- pad_data is sampled synchronously on the last HI cycle of each bit.

## Configuration
- Macro: SNES_PAD_EDGES_EN.
  - Defined: the EDGES register and its update logic are present as described above.
  - Undefined: no edge logic. Offset 1 reads 0 and writes to it are ignored. All other behaviour is unchanged.

## Test plan
All scenarios use CLK_DIV=2, LATCH_CYCLES=4, POLL_PERIOD=100, BASE_ADDR=13'h1F00.
- Reset, then read 1F00/1F01/1F02 -> all 0. pad_latch=0, pad_clk=1.
- Model drives pad_data for buttons 16'h8005 (active-low). sw 2 to 1F02 -> pad_latch high for 4 cycles, 16 pad_clk pulses. After 69 cycles, 1F00 reads 32'h0001_8005 and 1F01 reads 16'h8005.
- Write 1F00, then write 16'h0001 to 1F01 -> 1F00 = 32'h0000_8005, 1F01 = 16'h8004. Next poll with buttons 16'h8006 -> 1F01 = 16'h8006.
- sw 1 to 1F02 (poll_en) -> polls start every 100 idle cycles. A force written during busy produces no extra poll.
- Assert reset_n=0 mid-shift -> pad_latch=0, pad_clk=1 immediately. Registers read 0 after release.
- EDGES clear coinciding with COMMIT setting the same bit -> bit reads 1. With SNES_PAD_EDGES_EN undefined, 1F01 always reads 0.
